// File: rtl/cpu_pkg.sv
// Shared fetch-side constants and state encoding for the 16-bit CPU.
package cpu_pkg;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned INSTR_W     = 16;
  localparam int unsigned INSTR_BYTES = 2;
  localparam int unsigned COUNT_W     = 16;

  localparam logic [ADDR_W-1:0]  RESET_PC    = 8'h00;
  localparam logic [INSTR_W-1:0] HALT_OPCODE = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_slot.sv
// Single-entry valid/ready output register between fetch and decode.
module fetch_slot #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic               ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               free_c,
  output logic               xfer_c
);

  assign free_c = !instr_valid || ready;
  assign xfer_c = instr_valid && ready;

  // Flush beats load; an accepted entry with nothing behind it empties the slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (flush) begin
      instr_valid <= 1'b0;
    end else if (load) begin
      instr       <= load_instr;
      instr_pc    <= load_pc;
      instr_valid <= 1'b1;
    end else if (xfer_c) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, fills the decode slot, handles
// branch redirects and parks on HALT until restarted.
module fetch_controller
  import cpu_pkg::*;
#(
  parameter int unsigned         ADDR_W      = cpu_pkg::ADDR_W,
  parameter int unsigned         INSTR_W     = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]   RESET_PC    = cpu_pkg::RESET_PC,
  parameter logic [INSTR_W-1:0]  HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               halted,
  output logic               pc_wrap,
  output logic [COUNT_W-1:0] fetch_count
);

  localparam logic [ADDR_W-1:0]  PC_LAST   = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0]  PC_STEP   = ADDR_W'(INSTR_BYTES);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [ADDR_W-1:0] branch_pc_c;
  logic              load_c, flush_c, wrap_next;
  logic              slot_free_c, slot_xfer_c;
  logic              unused_c;

  assign imem_addr   = pc;
  assign branch_pc_c = {branch_target[ADDR_W-1:1], 1'b0};
  assign unused_c    = branch_target[0];

  fetch_slot #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_slot (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush_c),
    .load        (load_c),
    .load_instr  (imem_data),
    .load_pc     (pc),
    .ready       (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .free_c      (slot_free_c),
    .xfer_c      (slot_xfer_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      halted  <= 1'b0;
      pc_wrap <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      halted  <= (state_next == HALTED);
      pc_wrap <= wrap_next;
    end
  end

  // Next state, PC and slot control.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    load_c     = 1'b0;
    flush_c    = 1'b0;
    wrap_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (branch_valid) pc_next = branch_pc_c;
        if (start)        state_next = FETCH;
      end
      FETCH: begin
        if (branch_valid) begin
          pc_next = branch_pc_c;
          flush_c = 1'b1;
        end else if (slot_free_c) begin
          load_c = 1'b1;
          // HALT is delivered but the PC stays pointing at it.
          if (imem_data == HALT_OPCODE) begin
            state_next = HALTED;
          end else begin
            pc_next   = pc + PC_STEP;
            wrap_next = (pc == PC_LAST);
          end
        end
      end
      HALTED: begin
        if (start) begin
          pc_next    = RESET_PC;
          flush_c    = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Decode-accepted instruction counter, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= '0;
    end else if (slot_xfer_c && fetch_count != COUNT_MAX) begin
      fetch_count <= fetch_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller.
module tb_fetch_controller;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_valid;
  logic [7:0]  branch_target;
  logic        halted;
  logic        pc_wrap;
  logic [15:0] fetch_count;

  logic [7:0]  mem [256];
  int          n_checks;
  int          n_fail;

  fetch_controller dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .halted        (halted),
    .pc_wrap       (pc_wrap),
    .fetch_count   (fetch_count)
  );

  // Little-endian byte memory, read combinationally.
  assign imem_data = {mem[imem_addr | 8'h01], mem[imem_addr]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) mem[i] = 8'h80 | 8'(i);
    mem[8'h00] = 8'h21; mem[8'h01] = 8'hFE;
    mem[8'h02] = 8'h22; mem[8'h03] = 8'hFB;
    mem[8'h20] = 8'hD2; mem[8'h21] = 8'hF7;
    mem[8'h3E] = 8'h00; mem[8'h3F] = 8'h00;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    start         = 1'b0;
    instr_ready   = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 8'h00;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    load_program();
    do_reset();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    n_checks++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h want 00", imem_addr); end
    n_checks++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h want 0000", instr); end
    n_checks++; if ({halted, pc_wrap} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {halted, pc_wrap}); end
    n_checks++; if (fetch_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    // No start: stays idle, no capture.
    tick(); tick();
    n_checks++; if ({instr_valid, imem_addr} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL idle_hold got v=%b a=%h want v=0 a=00", instr_valid, imem_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL latency_n1 got v=%b want 0", instr_valid); end
    tick();
    n_checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 16'hFE21, 8'h00}) begin n_fail++; $display("FAIL stream_first got v=%b i=%h pc=%h want v=1 i=FE21 pc=00", instr_valid, instr, instr_pc); end
    n_checks++; if (imem_addr !== 8'h02) begin n_fail++; $display("FAIL stream_addr got %h want 02", imem_addr); end
    tick();
    n_checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 16'hFB22, 8'h02}) begin n_fail++; $display("FAIL stream_second got v=%b i=%h pc=%h want v=1 i=FB22 pc=02", instr_valid, instr, instr_pc); end
    n_checks++; if (fetch_count !== 16'd1) begin n_fail++; $display("FAIL stream_count got %0d want 1", fetch_count); end
  endtask

  task automatic test_stall();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({instr_valid, instr, imem_addr} !== {1'b1, 16'hFE21, 8'h02}) begin n_fail++; $display("FAIL stall_hold%0d got v=%b i=%h a=%h want v=1 i=FE21 a=02", i, instr_valid, instr, imem_addr); end
      n_checks++; if (fetch_count !== 16'd0) begin n_fail++; $display("FAIL stall_count%0d got %0d want 0", i, fetch_count); end
    end
    instr_ready = 1'b1;
    tick();
    n_checks++; if ({instr, instr_pc, fetch_count} !== {16'hFB22, 8'h02, 16'd1}) begin n_fail++; $display("FAIL stall_release got i=%h pc=%h c=%0d want i=FB22 pc=02 c=1", instr, instr_pc, fetch_count); end
  endtask

  task automatic test_branch_and_halt();
    int budget;
    // Continues in FETCH from test_stall with instr_ready high.
    branch_valid  = 1'b1;
    branch_target = 8'h21;
    tick();
    branch_valid  = 1'b0;
    n_checks++; if ({instr_valid, imem_addr} !== {1'b0, 8'h20}) begin n_fail++; $display("FAIL branch_flush got v=%b a=%h want v=0 a=20", instr_valid, imem_addr); end
    tick();
    n_checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 16'hF7D2, 8'h20}) begin n_fail++; $display("FAIL branch_target got v=%b i=%h pc=%h want v=1 i=F7D2 pc=20", instr_valid, instr, instr_pc); end
    budget = 0;
    while (!halted && budget < 40) begin
      tick();
      budget++;
    end
    n_checks++; if (budget !== 15) begin n_fail++; $display("FAIL halt_cycles got %0d want 15", budget); end
    n_checks++; if ({halted, instr_valid, instr, instr_pc, imem_addr} !== {1'b1, 1'b1, 16'h0000, 8'h3E, 8'h3E}) begin n_fail++; $display("FAIL halt_capture got h=%b v=%b i=%h pc=%h a=%h want h=1 v=1 i=0000 pc=3E a=3E", halted, instr_valid, instr, instr_pc, imem_addr); end
    tick();
    n_checks++; if ({halted, instr_valid, imem_addr} !== {1'b1, 1'b0, 8'h3E}) begin n_fail++; $display("FAIL halt_drain got h=%b v=%b a=%h want h=1 v=0 a=3E", halted, instr_valid, imem_addr); end
    branch_valid  = 1'b1;
    branch_target = 8'h10;
    tick();
    branch_valid  = 1'b0;
    tick();
    n_checks++; if ({halted, instr_valid, imem_addr} !== {1'b1, 1'b0, 8'h3E}) begin n_fail++; $display("FAIL halt_ignore_branch got h=%b v=%b a=%h want h=1 v=0 a=3E", halted, instr_valid, imem_addr); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if ({halted, instr_valid, imem_addr} !== {1'b0, 1'b0, 8'h00}) begin n_fail++; $display("FAIL restart_pc got h=%b v=%b a=%h want h=0 v=0 a=00", halted, instr_valid, imem_addr); end
    tick();
    n_checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 16'hFE21, 8'h00}) begin n_fail++; $display("FAIL restart_first got v=%b i=%h pc=%h want v=1 i=FE21 pc=00", instr_valid, instr, instr_pc); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) mem[i] = 8'h80 | 8'(i);
    do_reset();
    instr_ready   = 1'b1;
    start         = 1'b1;
    branch_valid  = 1'b1;
    branch_target = 8'hFD;
    tick();
    start        = 1'b0;
    branch_valid = 1'b0;
    n_checks++; if ({instr_valid, imem_addr} !== {1'b0, 8'hFC}) begin n_fail++; $display("FAIL idle_branch_start got v=%b a=%h want v=0 a=FC", instr_valid, imem_addr); end
    tick();
    n_checks++; if ({instr_pc, imem_addr, pc_wrap} !== {8'hFC, 8'hFE, 1'b0}) begin n_fail++; $display("FAIL wrap_pre got pc=%h a=%h w=%b want pc=FC a=FE w=0", instr_pc, imem_addr, pc_wrap); end
    tick();
    n_checks++; if ({instr_pc, imem_addr, pc_wrap} !== {8'hFE, 8'h00, 1'b1}) begin n_fail++; $display("FAIL wrap_pulse got pc=%h a=%h w=%b want pc=FE a=00 w=1", instr_pc, imem_addr, pc_wrap); end
    tick();
    n_checks++; if ({instr_pc, instr, pc_wrap} !== {8'h00, 16'h8180, 1'b0}) begin n_fail++; $display("FAIL wrap_post got pc=%h i=%h w=%b want pc=00 i=8180 w=0", instr_pc, instr, pc_wrap); end
  endtask

  task automatic test_reset_mid();
    load_program();
    do_reset();
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    instr_ready = 1'b0;
    tick();
    n_checks++; if ({instr_valid, fetch_count} !== {1'b1, 16'd2}) begin n_fail++; $display("FAIL pre_reset got v=%b c=%0d want v=1 c=2", instr_valid, fetch_count); end
    reset_n = 1'b0;
    #1;
    n_checks++; if ({instr_valid, instr, instr_pc, imem_addr, fetch_count, halted, pc_wrap} !== {1'b0, 16'h0, 8'h0, 8'h0, 16'h0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL async_reset got v=%b i=%h pc=%h a=%h c=%0d want all zero", instr_valid, instr, instr_pc, imem_addr, fetch_count); end
    tick();
    reset_n = 1'b1;
    tick(); tick();
    n_checks++; if ({instr_valid, imem_addr} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL reset_to_idle got v=%b a=%h want v=0 a=00", instr_valid, imem_addr); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    start         = 1'b0;
    instr_ready   = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 8'h00;
    test_reset();
    test_stream();
    test_stall();
    test_branch_and_halt();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Instruction fetch sequencer for the byte-addressed, 16-bit-instruction memory.
- Owns the program counter and drives the memory address, which is read combinationally.
- Registers the returned instruction into a single output slot with a valid/ready handshake to decode.
- Applies branch redirects and detects HALT, parking the machine until restarted.

Parameters:
- ADDR_W, 8, instruction memory byte-address width.
- INSTR_W, 16, instruction width; one instruction = two bytes.
- RESET_PC, 8'h00, PC loaded at reset and on restart from HALTED.
- HALT_OPCODE, 16'h0000, instruction value that stops fetching.

Ports:
- clk  input  1  clock.
- reset_n  input  1  reset; asynchronous, active-low.
- start  input  1  pulse; leaves IDLE/HALTED and begins fetching.
- imem_addr  output  ADDR_W  byte address to instruction memory; always even.
- imem_data  input  INSTR_W  combinational instruction read at imem_addr.
- instr  output  INSTR_W  registered instruction for decode.
- instr_pc  output  ADDR_W  address the held instr was fetched from.
- instr_valid  output  1  instr slot holds an instruction.
- instr_ready  input  1  decode accepts instr this cycle.
- branch_valid  input  1  redirect request.
- branch_target  input  ADDR_W  redirect address; bit 0 ignored (forced 0).
- halted  output  1  high in HALTED state.
- pc_wrap  output  1  one-cycle pulse when PC wraps 8'hFE -> 8'h00.
- fetch_count  output  16  count of instructions accepted by decode; saturates at 16'hFFFF.

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, pc_wrap=0, fetch_count=0.
- imem_addr = pc at all times; pc[0] is always 0.
- Slot handshake:
  - Transfer to decode when instr_valid && instr_ready; fetch_count increments.
  - Slot is free when !instr_valid || instr_ready.
- States: IDLE, FETCH, HALTED.
- IDLE:
  - start -> FETCH next cycle. No capture.
  - branch_valid loads pc; state stays IDLE.
- FETCH, per cycle, in priority order:
  1. branch_valid: pc <= {branch_target[7:1],1'b0}; instr_valid <= 0 (flush, even if not accepted); no capture this cycle. First instruction from the target is captured the next cycle.
  2. Slot free: instr <= imem_data, instr_pc <= pc, instr_valid <= 1, pc <= pc+2 (modulo 256). If pc==8'hFE, pc_wrap pulses. If imem_data==HALT_OPCODE, state -> HALTED and pc holds at the HALT address.
  3. Slot not free (stall): all registers hold.
- Latency: start at cycle N -> instr_valid=1 at N+2 (N+1 enter FETCH, capture at end of N+1). Steady state is one instruction per cycle with instr_ready held high.
- HALTED:
  - halted=1; no capture.
  - The HALT instruction stays valid until accepted, then instr_valid=0.
  - branch_valid is ignored.
  - start -> pc=RESET_PC, flush slot, state FETCH.
- Simultaneous start+branch_valid in IDLE: branch loads pc, then state goes to FETCH.
- Reset asserted mid-operation: immediate return to reset values; an in-flight slot is discarded.

Decomposition:
- Shared package (cpu_pkg):
  - Fetch state enum {IDLE, FETCH, HALTED}.
  - INSTR_BYTES=2.
  - HALT_OPCODE.
  - ADDR_W/INSTR_W constants.
- Sub-module fetch_slot: the single-entry valid/ready output register with flush input. The FSM, PC and counter stay in the top.

Test Plan:
- Memory preloaded with program bytes 21,FE,22,FB,...; reset, start pulse, instr_ready=1 -> instr=16'hFE21 @pc 0, then 16'hFB22 @pc 2, one per cycle; valid first at start+2.
- instr_ready=0 for 3 cycles after first capture -> instr stays 16'hFE21, imem_addr stays 8'h02, fetch_count unchanged; on release, 16'hFB22 follows.
- branch_valid with target 8'h21 in FETCH -> instr_valid drops next cycle, imem_addr=8'h20, following instr=16'hF7D2 @pc 8'h20.
- Run to address 62 (bytes 00,00) -> instr=16'h0000 delivered, halted=1, imem_addr holds 8'h3E, no further captures; start -> restart at 8'h00 with 16'hFE21.
- Program of all non-HALT words, fetch from 8'hFC -> pc_wrap pulses once as fetch at 8'hFE completes; next instr_pc=8'h00.
- reset_n low while instr_valid=1 mid-stall -> outputs immediately return to reset values, fetch_count=0, state IDLE.
